// File: rtl/fir_out_decimator.sv
// fir_out_decimator: round/scale FIR result, decimate, buffer in a FWFT FIFO with valid/ready output.
// Optional saturation of the range reduction is enabled by defining FIR_OUT_SAT_EN.
`default_nettype none

module fir_out_decimator #(
  parameter int RWIDTH = 34,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 15,
  parameter int DEPTH  = 4,
  parameter int DECW   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [RWIDTH-1:0]            in,
  input  logic                         in_en,
  input  logic [DECW-1:0]              dec,
  output logic [OWIDTH-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         clr_err,
  output logic [1:0]                   err,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = RWIDTH + 1 - SHIFT;
  localparam logic signed [RWIDTH:0] RND = {{RWIDTH{1'b0}}, 1'b1} << (SHIFT - 1);

  // Round-half-up then arithmetic shift; the shift is a slice of the widened sum.
  logic signed [RWIDTH:0] ext;
  logic signed [RWIDTH:0] sum;
  logic signed [SW-1:0]   scaled;
  logic [OWIDTH-1:0]      reduced;
  logic                   clamp;

  assign ext    = {in[RWIDTH-1], in};
  assign sum    = ext + RND;
  assign scaled = sum[RWIDTH:SHIFT];

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (OWIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    clamp   = 1'b0;
    reduced = scaled[OWIDTH-1:0];
    if (scaled > SAT_MAX) begin
      clamp   = 1'b1;
      reduced = SAT_MAX[OWIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      clamp   = 1'b1;
      reduced = SAT_MIN[OWIDTH-1:0];
    end
  end
`else
  assign reduced = scaled[OWIDTH-1:0];
  assign clamp   = 1'b0;
`endif

  // Decimation: dec is sampled on the first edge after reset and at every wrap.
  logic [DECW-1:0] phase;
  logic [DECW-1:0] eff_dec;
  logic            started;
  logic [DECW-1:0] dec_in;
  logic [DECW-1:0] cur_eff;
  logic            keep;
  logic            wrap;

  assign dec_in  = (dec == '0) ? DECW'(1) : dec;
  assign cur_eff = started ? eff_dec : dec_in;
  assign keep    = in_en && (phase == '0);
  assign wrap    = (phase == cur_eff - DECW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      eff_dec <= DECW'(1);
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (!started) eff_dec <= dec_in;
      if (in_en) begin
        if (wrap) begin
          phase   <= '0;
          eff_dec <= dec_in;
        end else begin
          phase <= phase + DECW'(1);
        end
      end
    end
  end

  logic              pipe_valid;
  logic [OWIDTH-1:0] pipe_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= keep;
      pipe_data  <= reduced;
    end
  end

  // FIFO with wrap-bit pointers; a full FIFO still accepts a write when it pops.
  logic [OWIDTH-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign push  = pipe_valid && (!full || pop);
  assign drop  = pipe_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pipe_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level     = wr_ptr - rd_ptr;

  // A set event on the same edge as clr_err takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else begin
      err[0] <= (keep && clamp) || (err[0] && !clr_err);
      err[1] <= drop || (err[1] && !clr_err);
    end
  end

endmodule

`default_nettype wire
